// File: rtl/game_pkg.sv
// Shared game-control types and constants.
// Holds the acceleration width, steering codes, button bit positions, the
// throttle mode enum, the per-car control payload and the steering encoder.
package game_pkg;

  localparam int unsigned ACC_WIDTH   = 3;
  localparam int unsigned OMEGA_WIDTH = 2;
  localparam int unsigned NUM_BTN     = 4;
  localparam int unsigned NUM_CARS    = 2;

  localparam logic [OMEGA_WIDTH-1:0] OMEGA_POS  = 2'b10;
  localparam logic [OMEGA_WIDTH-1:0] OMEGA_NEG  = 2'b00;
  localparam logic [OMEGA_WIDTH-1:0] OMEGA_HOLD = 2'b01;

  localparam int unsigned BTN_GAS   = 3;
  localparam int unsigned BTN_BRAKE = 2;
  localparam int unsigned BTN_LEFT  = 1;
  localparam int unsigned BTN_RIGHT = 0;

  typedef enum logic [1:0] {
    COAST = 2'd0,
    ACCEL = 2'd1,
    BRAKE = 2'd2
  } throttle_mode_t;

  // Per-car payload handed to game control.
  typedef struct packed {
    logic [ACC_WIDTH-1:0]   acc;
    logic [OMEGA_WIDTH-1:0] omega;
  } car_ctrl_t;

  // Left alone turns +1, right alone turns -1, anything else holds.
  function automatic logic [OMEGA_WIDTH-1:0] steer_code(input logic left, input logic right);
    logic [OMEGA_WIDTH-1:0] code;
    case ({left, right})
      2'b10:   code = OMEGA_POS;
      2'b01:   code = OMEGA_NEG;
      default: code = OMEGA_HOLD;
    endcase
    return code;
  endfunction

endpackage

// File: rtl/button_debouncer.sv
// Single-button synchroniser plus debouncer.
// Ports: i_clk, i_rst_n (async active-low), i_btn (raw, asynchronous),
//        o_db (debounced level, flips after DEBOUNCE_CYCLES stable cycles).
module button_debouncer #(
  parameter int unsigned DEBOUNCE_CYCLES = 250000
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_btn,
  output logic o_db
);

  localparam int unsigned CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             meta;
  logic             sync;
  logic [CNT_W-1:0] cnt;

  // Two-flop synchroniser for the asynchronous button.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      meta <= 1'b0;
      sync <= 1'b0;
    end else begin
      meta <= i_btn;
      sync <= meta;
    end
  end

  // Count consecutive disagreeing cycles; accept the new level on the last one.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      cnt  <= '0;
      o_db <= 1'b0;
    end else if (sync == o_db) begin
      cnt <= '0;
    end else if (cnt == CNT_LAST) begin
      cnt  <= '0;
      o_db <= ~o_db;
    end else begin
      cnt <= cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/car_input_encoder.sv
// Converts raw player buttons into per-car throttle level and steering code.
// Ports: i_clk, i_rst_n (async active-low), i_frame_tick (frame pulse),
//        i_car1_btn / i_car2_btn (raw {gas, brake, left, right}),
//        o_car1_acc / o_car2_acc (ramped level 0..ACC_MAX),
//        o_car1_omega / o_car2_omega (steering code),
//        o_car1_btn_db / o_car2_btn_db (debounced buttons).
module car_input_encoder
  import game_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 250000,
  parameter int unsigned RAMP_FRAMES     = 4,
  parameter int unsigned ACC_MAX         = 7
) (
  input  logic                   i_clk,
  input  logic                   i_rst_n,
  input  logic                   i_frame_tick,
  input  logic [NUM_BTN-1:0]     i_car1_btn,
  input  logic [NUM_BTN-1:0]     i_car2_btn,
  output logic [ACC_WIDTH-1:0]   o_car1_acc,
  output logic [ACC_WIDTH-1:0]   o_car2_acc,
  output logic [OMEGA_WIDTH-1:0] o_car1_omega,
  output logic [OMEGA_WIDTH-1:0] o_car2_omega,
  output logic [NUM_BTN-1:0]     o_car1_btn_db,
  output logic [NUM_BTN-1:0]     o_car2_btn_db
);

  localparam int unsigned RAMP_W = (RAMP_FRAMES > 1) ? $clog2(RAMP_FRAMES) : 1;
  localparam logic [RAMP_W-1:0]    RAMP_LAST = RAMP_W'(RAMP_FRAMES - 1);
  localparam logic [ACC_WIDTH-1:0] ACC_TOP   = ACC_WIDTH'(ACC_MAX);

  logic [NUM_BTN-1:0] raw  [NUM_CARS];
  logic [NUM_BTN-1:0] db   [NUM_CARS];
  car_ctrl_t          ctrl [NUM_CARS];

  assign raw[0] = i_car1_btn;
  assign raw[1] = i_car2_btn;

  for (genvar c = 0; c < NUM_CARS; c++) begin : g_car

    logic [NUM_BTN-1:0] db_c;

    for (genvar b = 0; b < NUM_BTN; b++) begin : g_btn
      button_debouncer #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
      ) u_debouncer (
        .i_clk  (i_clk),
        .i_rst_n(i_rst_n),
        .i_btn  (raw[c][b]),
        .o_db   (db_c[b])
      );
    end

    assign db[c] = db_c;

    throttle_mode_t         mode_q,  mode_d, tick_mode;
    logic [RAMP_W-1:0]      ramp_q,  ramp_d;
    logic [ACC_WIDTH-1:0]   acc_q,   acc_d;
    logic [OMEGA_WIDTH-1:0] omega_q, omega_d;

    // Throttle/steering state register.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
        mode_q  <= COAST;
        ramp_q  <= '0;
        acc_q   <= '0;
        omega_q <= OMEGA_HOLD;
      end else begin
        mode_q  <= mode_d;
        ramp_q  <= ramp_d;
        acc_q   <= acc_d;
        omega_q <= omega_d;
      end
    end

    // Frame-tick update: brake beats gas; a mode change restarts the ramp.
    always_comb begin
      mode_d    = mode_q;
      ramp_d    = ramp_q;
      acc_d     = acc_q;
      omega_d   = omega_q;
      tick_mode = COAST;
      if (db_c[BTN_BRAKE]) begin
        tick_mode = BRAKE;
      end else if (db_c[BTN_GAS]) begin
        tick_mode = ACCEL;
      end

      if (i_frame_tick) begin
        omega_d = steer_code(db_c[BTN_LEFT], db_c[BTN_RIGHT]);
        if (tick_mode != mode_q) begin
          mode_d = tick_mode;
          ramp_d = '0;
          if (tick_mode == BRAKE) begin
            acc_d = '0;
          end
        end else if (tick_mode == BRAKE) begin
          acc_d  = '0;
          ramp_d = '0;
        end else if (ramp_q == RAMP_LAST) begin
          ramp_d = '0;
          if (tick_mode == ACCEL) begin
            if (acc_q < ACC_TOP) begin
              acc_d = acc_q + ACC_WIDTH'(1);
            end
          end else if (acc_q != '0) begin
            acc_d = acc_q - ACC_WIDTH'(1);
          end
        end else begin
          ramp_d = ramp_q + RAMP_W'(1);
        end
      end
    end

    assign ctrl[c] = car_ctrl_t'{acc: acc_q, omega: omega_q};

  end

  assign o_car1_acc    = ctrl[0].acc;
  assign o_car2_acc    = ctrl[1].acc;
  assign o_car1_omega  = ctrl[0].omega;
  assign o_car2_omega  = ctrl[1].omega;
  assign o_car1_btn_db = db[0];
  assign o_car2_btn_db = db[1];

endmodule

// File: tb/tb_car_input_encoder.sv
// Self-checking bench for car_input_encoder with a behavioural reference model.
module tb_car_input_encoder;

  localparam int unsigned DC   = 4;
  localparam int unsigned RF   = 2;
  localparam int          AMAX = 7;

  logic       clk   = 1'b0;
  logic       rst_n = 1'b0;
  logic       tick  = 1'b0;
  logic [3:0] btn1  = 4'h0;
  logic [3:0] btn2  = 4'h0;
  logic [2:0] acc1, acc2;
  logic [1:0] omega1, omega2;
  logic [3:0] db1, db2;

  always #5 clk = ~clk;

  car_input_encoder #(
    .DEBOUNCE_CYCLES(DC),
    .RAMP_FRAMES    (RF),
    .ACC_MAX        (AMAX)
  ) dut (
    .i_clk        (clk),
    .i_rst_n      (rst_n),
    .i_frame_tick (tick),
    .i_car1_btn   (btn1),
    .i_car2_btn   (btn2),
    .o_car1_acc   (acc1),
    .o_car2_acc   (acc2),
    .o_car1_omega (omega1),
    .o_car2_omega (omega2),
    .o_car1_btn_db(db1),
    .o_car2_btn_db(db2)
  );

  int n_checks = 0;
  int n_fail   = 0;
  bit done     = 1'b0;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // Button b: car = b/4, bit = b%4. Debounce is a window rule: the accepted
  // level flips when the last DC synchronised samples all disagree with it.
  bit m_s1 [8];
  bit m_s2 [8];
  bit m_db [8];
  bit m_hist [8][DC];
  int m_mode  [2];   // 0 coast, 1 accel, 2 brake
  int m_ramp  [2];
  int m_acc   [2];
  int m_omega [2];

  bit t_all;
  int t_md;
  bit t_g, t_br, t_l, t_r;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int b = 0; b < 8; b++) begin
        m_s1[b] <= 1'b0;
        m_s2[b] <= 1'b0;
        m_db[b] <= 1'b0;
        for (int k = 0; k < DC; k++) m_hist[b][k] <= 1'b0;
      end
      for (int c = 0; c < 2; c++) begin
        m_mode[c]  <= 0;
        m_ramp[c]  <= 0;
        m_acc[c]   <= 0;
        m_omega[c] <= 1;
      end
    end else begin
      if (tick) begin
        for (int c = 0; c < 2; c++) begin
          t_g  = m_db[c*4+3];
          t_br = m_db[c*4+2];
          t_l  = m_db[c*4+1];
          t_r  = m_db[c*4+0];
          t_md = t_br ? 2 : (t_g ? 1 : 0);
          m_omega[c] <= (t_l && !t_r) ? 2 : ((t_r && !t_l) ? 0 : 1);
          if (t_md != m_mode[c]) begin
            m_mode[c] <= t_md;
            m_ramp[c] <= 0;
            if (t_md == 2) m_acc[c] <= 0;
          end else if (t_md == 2) begin
            m_acc[c]  <= 0;
            m_ramp[c] <= 0;
          end else if (m_ramp[c] == RF - 1) begin
            m_ramp[c] <= 0;
            if (t_md == 1) m_acc[c] <= (m_acc[c] + 1 > AMAX) ? AMAX : m_acc[c] + 1;
            else           m_acc[c] <= (m_acc[c] - 1 < 0) ? 0 : m_acc[c] - 1;
          end else begin
            m_ramp[c] <= m_ramp[c] + 1;
          end
        end
      end
      for (int b = 0; b < 8; b++) begin
        t_all = (m_s2[b] != m_db[b]);
        for (int k = 0; k < DC - 1; k++) t_all = t_all && (m_hist[b][k] != m_db[b]);
        if (t_all) m_db[b] <= ~m_db[b];
        m_hist[b][0] <= m_s2[b];
        for (int k = 1; k < DC; k++) m_hist[b][k] <= m_hist[b][k-1];
        m_s2[b] <= m_s1[b];
        m_s1[b] <= (b < 4) ? btn1[b] : btn2[b-4];
      end
    end
  end

  // Every-cycle comparison of all outputs against the model.
  always @(negedge clk) begin
    if (!done) begin
      check("car1_acc",   int'(acc1),   m_acc[0]);
      check("car2_acc",   int'(acc2),   m_acc[1]);
      check("car1_omega", int'(omega1), m_omega[0]);
      check("car2_omega", int'(omega2), m_omega[1]);
      check("car1_db",    int'(db1), int'({m_db[3], m_db[2], m_db[1], m_db[0]}));
      check("car2_db",    int'(db2), int'({m_db[7], m_db[6], m_db[5], m_db[4]}));
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  // One tick pulse; returns at the negedge after the tick was sampled.
  task automatic tick_once();
    @(negedge clk) tick = 1'b1;
    @(negedge clk) tick = 1'b0;
  endtask

  int exp_up   [20] = '{0,1,1,2,2,3,3,4,4,5,5,6,6,7,7,7,7,7,7,7};
  int exp_down [6]  = '{3,2,2,1,1,0};

  initial begin
    // Reset with every button pressed.
    btn1 = 4'hF;
    btn2 = 4'hF;
    cycles(3);
    check("rst_acc1",   int'(acc1),   0);
    check("rst_omega1", int'(omega1), 1);
    check("rst_omega2", int'(omega2), 1);
    check("rst_db1",    int'(db1),    0);
    check("rst_db2",    int'(db2),    0);
    @(negedge clk) rst_n = 1'b1;
    for (int k = 1; k <= 5; k++) begin
      @(negedge clk);
      check("rst_db_hold", int'(db1), 0);
    end
    @(negedge clk);
    check("rst_db_rise", int'(db1), 15);
    btn1 = 4'h0;
    btn2 = 4'h0;
    cycles(8);

    // Three-cycle glitch on gas never gets through.
    @(negedge clk) btn1 = 4'h8;
    cycles(2);
    @(negedge clk) btn1 = 4'h0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      check("glitch_db", int'(db1[3]), 0);
    end

    // Held gas appears 2 + DC = 6 cycles after the edge.
    @(negedge clk) btn1 = 4'h8;
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      check("hold_db", int'(db1[3]), (k >= 6) ? 1 : 0);
    end

    // Ramp up: mode-change tick, then 20 back-to-back ticks.
    tick_once();
    check("ramp_mode_change", int'(acc1), 0);
    @(negedge clk) tick = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (i == 19) tick = 1'b0;
      check("ramp_acc", int'(acc1), exp_up[i]);
    end
    check("ramp_car2", int'(acc2), 0);

    // Reset mid-ramp and mid-debounce clears everything.
    @(negedge clk) btn2 = 4'h2;
    cycles(3);
    @(negedge clk) rst_n = 1'b0;
    cycles(2);
    check("midrst_acc1", int'(acc1), 0);
    check("midrst_db1",  int'(db1),  0);
    check("midrst_db2",  int'(db2),  0);
    btn2 = 4'h0;
    @(negedge clk) rst_n = 1'b1;
    cycles(8);

    // Bring acc to 5 with gas, then gas+brake forces 0.
    tick_once();
    for (int i = 0; i < 10; i++) tick_once();
    check("pre_brake_acc", int'(acc1), 5);
    btn1 = 4'hC;
    cycles(8);
    tick_once();
    check("brake_acc", int'(acc1), 0);
    btn1 = 4'h0;
    cycles(8);
    for (int i = 0; i < 4; i++) begin
      tick_once();
      check("after_brake_acc", int'(acc1), 0);
    end

    // Coast decay from 3.
    btn1 = 4'h8;
    cycles(8);
    tick_once();
    for (int i = 0; i < 6; i++) tick_once();
    check("pre_coast_acc", int'(acc1), 3);
    btn1 = 4'h0;
    cycles(8);
    tick_once();
    check("coast_mode_change", int'(acc1), 3);
    for (int i = 0; i < 6; i++) begin
      tick_once();
      check("coast_acc", int'(acc1), exp_down[i]);
    end

    // Steering on car 1 only.
    btn1 = 4'h2;
    cycles(8);
    check("steer_wait", int'(omega1), 1);
    tick_once();
    check("steer_left", int'(omega1), 2);
    check("steer_car2", int'(omega2), 1);
    btn1 = 4'h1;
    cycles(8);
    tick_once();
    check("steer_right", int'(omega1), 0);
    btn1 = 4'h3;
    cycles(8);
    tick_once();
    check("steer_both", int'(omega1), 1);
    check("steer_car2b", int'(omega2), 1);
    btn1 = 4'h0;
    cycles(8);

    // Tick in the same cycle as a debounce flip sees the old level.
    @(negedge clk) btn2 = 4'h2;
    cycles(5);
    tick = 1'b1;
    @(negedge clk) tick = 1'b0;
    check("flip_tick_db",    int'(db2[1]), 1);
    check("flip_tick_omega", int'(omega2), 1);
    tick_once();
    check("flip_next_omega", int'(omega2), 2);
    btn2 = 4'h0;
    cycles(8);

    // Simultaneous gas on both cars.
    @(negedge clk) begin
      btn1 = 4'h8;
      btn2 = 4'h8;
    end
    cycles(8);
    for (int i = 0; i < 3; i++) tick_once();
    check("both_acc1", int'(acc1), 1);
    check("both_acc2", int'(acc2), 1);

    cycles(2);
    done = 1'b1;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
